// File: rtl/sign_extend_pkg.sv
// Shared constants for the immediate sign/zero extender.
// Default widths match a 16-bit immediate feeding a 32-bit datapath.
package sign_extend_pkg;

  localparam int IMM_WIDTH  = 16;
  localparam int WORD_WIDTH = 32;

  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

endpackage

// File: rtl/sign_extend_core.sv
// Combinational extension of an n-bit field to m bits.
// Upper bits come from the field MSB or are forced to zero.
module sign_extend_core
  import sign_extend_pkg::*;
#(
  parameter int REG_IN_SIZE  = IMM_WIDTH,
  parameter int REG_OUT_SIZE = WORD_WIDTH
) (
  input  logic [REG_IN_SIZE-1:0]  x_i,
  input  logic                    zero_ext_i,
  output logic [REG_OUT_SIZE-1:0] y_o
);

  if (REG_IN_SIZE < 1 || REG_OUT_SIZE < REG_IN_SIZE) begin : g_bad
    $fatal(1, "sign_extend: need REG_OUT_SIZE >= REG_IN_SIZE >= 1");
  end

  if (REG_OUT_SIZE > REG_IN_SIZE) begin : g_ext
    logic fill;
    assign fill = (zero_ext_i == EXT_ZERO) ? 1'b0
                                           : x_i[REG_IN_SIZE-1];
    assign y_o  = {{(REG_OUT_SIZE-REG_IN_SIZE){fill}}, x_i};
  end else if (REG_OUT_SIZE == REG_IN_SIZE) begin : g_pass
    // Equal widths: nothing to fill, mode is irrelevant.
    logic unused_mode;
    assign unused_mode = zero_ext_i;
    assign y_o = x_i;
  end else begin : g_none
    logic unused_in;
    assign unused_in = ^{x_i, zero_ext_i};
    assign y_o = '0;
  end

endmodule

// File: rtl/sign_extend.sv
// Registered sign/zero extender with a valid flag.
// One-cycle latency; output value holds when no valid input arrives.
module sign_extend
  import sign_extend_pkg::*;
#(
  parameter int REG_IN_SIZE  = IMM_WIDTH,
  parameter int REG_OUT_SIZE = WORD_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_valid,
  input  logic                    i_zero_ext,
  input  logic [REG_IN_SIZE-1:0]  i_reg,
  output logic [REG_OUT_SIZE-1:0] o_reg,
  output logic                    o_valid
);

  logic [REG_OUT_SIZE-1:0] ext;
  logic [REG_OUT_SIZE-1:0] reg_d, reg_q;
  logic                    valid_d, valid_q;

  sign_extend_core #(
    .REG_IN_SIZE (REG_IN_SIZE),
    .REG_OUT_SIZE(REG_OUT_SIZE)
  ) u_core (
    .x_i       (i_reg),
    .zero_ext_i(i_zero_ext),
    .y_o       (ext)
  );

  always_comb begin
    reg_d   = reg_q;
    valid_d = i_valid;
    if (i_valid) reg_d = ext;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      reg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      reg_q   <= reg_d;
      valid_q <= valid_d;
    end
  end

  assign o_reg   = reg_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_sign_extend.sv
// Bench for sign_extend: directed cases plus random stream
// against an arithmetic model, over three width configurations.
module tb_sign_extend;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_zero_ext;
  logic [15:0] i_reg;

  logic [31:0] o32;
  logic        v32;
  logic [31:0] o8;
  logic        v8;
  logic [15:0] o16;
  logic        v16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sign_extend #(.REG_IN_SIZE(16), .REG_OUT_SIZE(32)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_valid(i_valid),
    .i_zero_ext(i_zero_ext), .i_reg(i_reg),
    .o_reg(o32), .o_valid(v32)
  );

  sign_extend #(.REG_IN_SIZE(8), .REG_OUT_SIZE(32)) dut8 (
    .i_clk(clk), .i_reset(rst_n), .i_valid(i_valid),
    .i_zero_ext(i_zero_ext), .i_reg(i_reg[7:0]),
    .o_reg(o8), .o_valid(v8)
  );

  sign_extend #(.REG_IN_SIZE(16), .REG_OUT_SIZE(16)) dut16 (
    .i_clk(clk), .i_reset(rst_n), .i_valid(i_valid),
    .i_zero_ext(i_zero_ext), .i_reg(i_reg),
    .o_reg(o16), .o_valid(v16)
  );

  // Value-level model: a negative n-bit number gains 2^m - 2^n.
  function automatic longint unsigned ref_ext(
    input longint unsigned x, input bit z,
    input int inw, input int outw);
    longint unsigned v;
    v = x % (64'd1 << inw);
    if (!z && outw > inw && v >= (64'd1 << (inw - 1)))
      v = v + (64'd1 << outw) - (64'd1 << inw);
    return v;
  endfunction

  task automatic cycle(input logic v, input logic z,
                       input logic [15:0] x);
    i_valid    = v;
    i_zero_ext = z;
    i_reg      = x;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(1'b1, 1'b0, 16'hFFFF);
    cycle(1'b1, 1'b0, 16'hFFFF);
    checks++;
    if (o32 !== 32'h0 || v32 !== 1'b0) begin
      failures++;
      $display("FAIL reset got=%h/%b exp=00000000/0", o32, v32);
    end
    checks++;
    if (o8 !== 32'h0 || v8 !== 1'b0 || o16 !== 16'h0 || v16 !== 1'b0) begin
      failures++;
      $display("FAIL reset_params got=%h/%b %h/%b exp=0/0",
               o8, v8, o16, v16);
    end
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 16'h1234);
    checks++;
    if (o32 !== 32'h00001234 || v32 !== 1'b1) begin
      failures++;
      $display("FAIL reset_release got=%h/%b exp=00001234/1", o32, v32);
    end
  endtask

  task automatic test_sign();
    logic [15:0] xs [4] = '{16'h5555, 16'hCAFD, 16'h8000, 16'h7FFF};
    logic [31:0] es [4] = '{32'h00005555, 32'hFFFFCAFD,
                            32'hFFFF8000, 32'h00007FFF};
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 1'b0, xs[k]);
      checks++;
      if (o32 !== es[k] || v32 !== 1'b1) begin
        failures++;
        $display("FAIL sign_%0d got=%h/%b exp=%h/1", k, o32, v32, es[k]);
      end
    end
  endtask

  task automatic test_zero();
    cycle(1'b1, 1'b1, 16'hCAFD);
    checks++;
    if (o32 !== 32'h0000CAFD || v32 !== 1'b1) begin
      failures++;
      $display("FAIL zero_cafd got=%h/%b exp=0000cafd/1", o32, v32);
    end
    cycle(1'b1, 1'b1, 16'hFFFF);
    checks++;
    if (o32 !== 32'h0000FFFF || v32 !== 1'b1) begin
      failures++;
      $display("FAIL zero_ffff got=%h/%b exp=0000ffff/1", o32, v32);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b0, 16'h0001);
    checks++;
    if (o32 !== 32'h00000001 || v32 !== 1'b1) begin
      failures++;
      $display("FAIL stream_0 got=%h/%b exp=00000001/1", o32, v32);
    end
    cycle(1'b1, 1'b0, 16'hFFFE);
    checks++;
    if (o32 !== 32'hFFFFFFFE || v32 !== 1'b1) begin
      failures++;
      $display("FAIL stream_1 got=%h/%b exp=fffffffe/1", o32, v32);
    end
    cycle(1'b0, 1'b1, 16'h1234);
    checks++;
    if (o32 !== 32'hFFFFFFFE || v32 !== 1'b0) begin
      failures++;
      $display("FAIL stream_hold got=%h/%b exp=fffffffe/0", o32, v32);
    end
    cycle(1'b0, 1'b0, 16'h0000);
    checks++;
    if (o32 !== 32'hFFFFFFFE || v32 !== 1'b0) begin
      failures++;
      $display("FAIL stream_hold2 got=%h/%b exp=fffffffe/0", o32, v32);
    end
  endtask

  task automatic test_params();
    cycle(1'b1, 1'b0, 16'h8080);
    checks++;
    if (o8 !== 32'hFFFFFF80 || v8 !== 1'b1) begin
      failures++;
      $display("FAIL w8_sign got=%h/%b exp=ffffff80/1", o8, v8);
    end
    cycle(1'b1, 1'b1, 16'h8080);
    checks++;
    if (o8 !== 32'h00000080) begin
      failures++;
      $display("FAIL w8_zero got=%h exp=00000080", o8);
    end
    for (int z = 0; z < 2; z++) begin
      cycle(1'b1, z[0], 16'h8001);
      checks++;
      if (o16 !== 16'h8001 || v16 !== 1'b1) begin
        failures++;
        $display("FAIL w16_pass_z%0d got=%h/%b exp=8001/1", z, o16, v16);
      end
    end
  endtask

  task automatic test_midstream_reset();
    cycle(1'b1, 1'b0, 16'h8000);
    rst_n = 1'b0;
    cycle(1'b1, 1'b0, 16'h4321);
    checks++;
    if (o32 !== 32'h0 || v32 !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got=%h/%b exp=00000000/0", o32, v32);
    end
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 16'hF00D);
    checks++;
    if (o32 !== 32'hFFFFF00D || v32 !== 1'b1) begin
      failures++;
      $display("FAIL mid_release got=%h/%b exp=fffff00d/1", o32, v32);
    end
  endtask

  task automatic test_random();
    logic [31:0] e32 = 32'hFFFFF00D;
    logic [31:0] e8  = ref_ext(64'h0D, 1'b0, 8, 32);
    logic [15:0] e16 = 16'hF00D;
    logic        ev;
    logic        v, z;
    logic [15:0] x;
    for (int n = 0; n < 300; n++) begin
      v = ($urandom_range(0, 3) != 0);
      z = $urandom_range(0, 1);
      x = 16'($urandom);
      if (n % 16 == 0) x = {x[15], 15'h0};
      cycle(v, z, x);
      ev = v;
      if (v) begin
        e32 = 32'(ref_ext(64'(x), z, 16, 32));
        e8  = 32'(ref_ext(64'(x), z, 8, 32));
        e16 = 16'(ref_ext(64'(x), z, 16, 16));
      end
      checks++;
      if (o32 !== e32 || v32 !== ev || o8 !== e8 || v8 !== ev ||
          o16 !== e16 || v16 !== ev) begin
        failures++;
        $display("FAIL rand_%0d got=%h/%h/%h v=%b%b%b exp=%h/%h/%h v=%b",
                 n, o32, o8, o16, v32, v8, v16, e32, e8, e16, ev);
      end
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_zero_ext = 1'b0;
    i_reg      = '0;
    test_reset();
    test_sign();
    test_zero();
    test_back_to_back();
    test_params();
    test_midstream_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
